// File: rtl/sseg_value_encoder.sv
// Binary-to-seven-segment encoder: 14-bit value -> four active-low common-anode bytes
// via iterative double-dabble. Define SSEG_LZ_BLANK_EN to blank leading zero digits.
module sseg_value_encoder (
    input  logic        clk_s,
    input  logic        rst_s,
    input  logic [13:0] val_s,
    input  logic [3:0]  dp_s,
    input  logic        load_s,
    output logic [31:0] sseg_s,
    output logic        busy_s,
    output logic        done_s,
    output logic        ovf_s
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [13:0] val_sh;
    logic [3:0]  dp_lat;
    logic        ovf_lat;
    logic [15:0] bcd;
    logic [14:0] bcd_adj;
    logic [3:0]  cnt;
    logic [3:0]  blank;
    logic [31:0] sseg_nxt;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk_s or negedge rst_s) begin
        if (!rst_s) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_s) state_nxt = SHIFT;
            SHIFT:   if (cnt == 4'd13) state_nxt = ENCODE;
            ENCODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_s = (state != IDLE);
    end

    // Only 15 bits of the adjusted value survive the shift, so the top nibble keeps 3 bits.
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        bcd_adj[14:12] = (bcd[15:12] >= 4'd5) ? bcd[14:12] + 3'd3 : bcd[14:12];
    end

    always_comb begin
        blank = '0;
`ifdef SSEG_LZ_BLANK_EN
        blank[3] = (bcd[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd[11:8] == 4'd0);
        blank[1] = blank[2] && (bcd[7:4] == 4'd0);
`endif
        sseg_nxt = '1;
        if (ovf_lat) begin
            sseg_nxt = 32'hBFBFBFBF;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                sseg_nxt[8*i +: 8] = blank[i] ? 8'hFF : seg_code(bcd[4*i +: 4]);
                sseg_nxt[8*i + 7]  = sseg_nxt[8*i + 7] & ~dp_lat[i];
            end
        end
    end

    always_ff @(posedge clk_s or negedge rst_s) begin
        if (!rst_s) begin
            val_sh  <= '0;
            dp_lat  <= '0;
            ovf_lat <= 1'b0;
            bcd     <= '0;
            cnt     <= '0;
            sseg_s  <= '1;
            done_s  <= 1'b0;
            ovf_s   <= 1'b0;
        end else begin
            done_s <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_s) begin
                        val_sh  <= val_s;
                        dp_lat  <= dp_s;
                        ovf_lat <= (val_s > 14'd9999);
                        bcd     <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    bcd    <= {bcd_adj, val_sh[13]};
                    val_sh <= {val_sh[12:0], 1'b0};
                    cnt    <= cnt + 4'd1;
                end
                ENCODE: begin
                    sseg_s <= sseg_nxt;
                    ovf_s  <= ovf_lat;
                    done_s <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_value_encoder.sv
// Self-checking bench for sseg_value_encoder: vector table, scoreboard on done_s, corner sequences.
module tb_sseg_value_encoder;

`ifdef SSEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk_s  = 1'b0;
    logic        rst_s  = 1'b1;
    logic [13:0] val_s  = '0;
    logic [3:0]  dp_s   = '0;
    logic        load_s = 1'b0;
    logic [31:0] sseg_s;
    logic        busy_s;
    logic        done_s;
    logic        ovf_s;

    sseg_value_encoder dut (
        .clk_s  (clk_s),
        .rst_s  (rst_s),
        .val_s  (val_s),
        .dp_s   (dp_s),
        .load_s (load_s),
        .sseg_s (sseg_s),
        .busy_s (busy_s),
        .done_s (done_s),
        .ovf_s  (ovf_s)
    );

    always #5 clk_s = ~clk_s;

    typedef struct {
        logic [31:0] sseg;
        logic        ovf;
        int          id;
    } exp_t;

    typedef struct {
        logic [13:0] val;
        logic [3:0]  dp;
        logic [31:0] plain;
        logic [31:0] lz;
        logic        ovf;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[12];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        $display("FAIL %s: got no done_s, expected done_s within budget", name);
    endtask

    // Scoreboard: every done_s pops one expected result; otherwise sseg_s must hold.
    logic [31:0] last_sseg;
    logic        last_rst  = 1'b0;
    logic        last_done = 1'b0;
    always @(negedge clk_s) begin
        if (done_s) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done_s=1, expected no pending conversion");
            end else begin
                e = sb.pop_front();
                check($sformatf("vec%0d_sseg", e.id), sseg_s, e.sseg);
                check($sformatf("vec%0d_ovf", e.id), {31'b0, ovf_s}, {31'b0, e.ovf});
            end
        end else if (rst_s && last_rst) begin
            check("sseg_stable", sseg_s, last_sseg);
        end
        if (last_done) check("done_width", {31'b0, done_s}, 32'd0);
        last_sseg = sseg_s;
        last_rst  = rst_s;
        last_done = done_s;
    end

    task automatic run_conv(input logic [13:0] v, input logic [3:0] d, input logic [31:0] es,
                            input logic eo, input int id, input int glitch_at, input bit release_rst);
        int n;
        int busy_n;
        @(negedge clk_s);
        if (release_rst) rst_s = 1'b1;
        val_s  = v;
        dp_s   = d;
        load_s = 1'b1;
        sb.push_back('{es, eo, id});
        n      = 0;
        busy_n = 0;
        do begin
            @(negedge clk_s);
            n++;
            if (n == 1 || n == glitch_at + 1) begin
                load_s = 1'b0;
                val_s  = 14'($urandom_range(16383));
                dp_s   = 4'($urandom_range(15));
            end
            if (n == glitch_at) begin
                val_s  = 14'd4321;
                dp_s   = 4'b1111;
                load_s = 1'b1;
            end
            if (busy_s) busy_n++;
        end while (!done_s && n < 40);
        if (!done_s) begin
            fail_timeout($sformatf("vec%0d_done", id));
        end else begin
            check($sformatf("vec%0d_latency", id), n, 32'd16);
            check($sformatf("vec%0d_busy_cycles", id), busy_n, 32'd15);
        end
    endtask

    initial begin
        int first;
        int second;
        int n;

        tbl[0]  = '{14'd1234,  4'b0000, 32'hF9A4B099, 32'hF9A4B099, 1'b0};
        tbl[1]  = '{14'd7,     4'b0000, 32'hC0C0C0F8, 32'hFFFFFFF8, 1'b0};
        tbl[2]  = '{14'd0,     4'b0000, 32'hC0C0C0C0, 32'hFFFFFFC0, 1'b0};
        tbl[3]  = '{14'd10000, 4'b0000, 32'hBFBFBFBF, 32'hBFBFBFBF, 1'b1};
        tbl[4]  = '{14'd9999,  4'b0000, 32'h90909090, 32'h90909090, 1'b0};
        tbl[5]  = '{14'd5,     4'b0100, 32'hC040C092, 32'hFF7FFF92, 1'b0};
        tbl[6]  = '{14'd16383, 4'b1111, 32'hBFBFBFBF, 32'hBFBFBFBF, 1'b1};
        tbl[7]  = '{14'd9,     4'b1111, 32'h40404010, 32'h7F7F7F10, 1'b0};
        tbl[8]  = '{14'd805,   4'b0001, 32'hC080C012, 32'hFF80C012, 1'b0};
        tbl[9]  = '{14'd1000,  4'b1000, 32'h79C0C0C0, 32'h79C0C0C0, 1'b0};
        tbl[10] = '{14'd4567,  4'b0000, 32'h999282F8, 32'h999282F8, 1'b0};
        tbl[11] = '{14'd60,    4'b0000, 32'hC0C082C0, 32'hFFFF82C0, 1'b0};

        #2 rst_s = 1'b0;
        #20;
        check("reset_sseg", sseg_s, 32'hFFFFFFFF);
        check("reset_busy", {31'b0, busy_s}, 32'd0);
        check("reset_done", {31'b0, done_s}, 32'd0);
        check("reset_ovf",  {31'b0, ovf_s},  32'd0);

        for (int i = 0; i < 12; i++) begin
            run_conv(tbl[i].val, tbl[i].dp, LZ ? tbl[i].lz : tbl[i].plain, tbl[i].ovf, i, 0, i == 0);
        end

        // Load while busy must be ignored; then leave ovf set before the abort.
        run_conv(14'd1234, 4'b0000, 32'hF9A4B099, 1'b0, 100, 5, 1'b0);
        run_conv(14'd10000, 4'b0000, 32'hBFBFBFBF, 1'b1, 101, 0, 1'b0);

        @(negedge clk_s);
        val_s  = 14'd4321;
        dp_s   = 4'b1111;
        load_s = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_s);
            if (k == 1) load_s = 1'b0;
        end
        check("abort_busy_before", {31'b0, busy_s}, 32'd1);
        #2 rst_s = 1'b0;
        #1;
        check("abort_sseg", sseg_s, 32'hFFFFFFFF);
        check("abort_busy", {31'b0, busy_s}, 32'd0);
        check("abort_done", {31'b0, done_s}, 32'd0);
        check("abort_ovf",  {31'b0, ovf_s},  32'd0);
        repeat (20) @(negedge clk_s);
        check("abort_no_done", {31'b0, done_s}, 32'd0);

        run_conv(14'd42, 4'b0000, LZ ? 32'hFFFF99A4 : 32'hC0C099A4, 1'b0, 102, 0, 1'b1);

        // load_s held high: conversions every 16 cycles.
        @(negedge clk_s);
        val_s  = 14'd4567;
        dp_s   = 4'b0000;
        load_s = 1'b1;
        sb.push_back('{32'h999282F8, 1'b0, 103});
        sb.push_back('{32'h999282F8, 1'b0, 104});
        first  = -1;
        second = -1;
        n      = 0;
        while (n < 60 && second < 0) begin
            @(negedge clk_s);
            n++;
            if (done_s) begin
                if (first < 0) first = n;
                else begin
                    second = n;
                    load_s = 1'b0;
                end
            end
        end
        load_s = 1'b0;
        if (second < 0) begin
            fail_timeout("b2b_done");
        end else begin
            check("b2b_first_latency", first, 32'd16);
            check("b2b_period", second - first, 32'd16);
        end

        repeat (20) @(negedge clk_s);
        check("final_idle", {31'b0, busy_s}, 32'd0);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sseg_value_encoder.md
SSEG_VALUE_ENCODER -- requirements
Module: sseg_value_encoder

Interface
REQ-001 Port `clk_s`, input, 1 bit: sole clock, rising edge.
REQ-002 Port `rst_s`, input, 1 bit: asynchronous, active-low reset.
REQ-003 Port `val_s`, input, 14 bits: unsigned binary value to display.
REQ-004 Port `dp_s`, input, 4 bits: decimal-point request per digit, active-high; bit 3 is the leftmost digit.
REQ-005 Port `load_s`, input, 1 bit: start-conversion request, sampled each rising edge.
REQ-006 Port `sseg_s`, output, 32 bits: four segment bytes for the downstream scanner; [31:24] thousands (leftmost digit) down to [7:0] units.
REQ-007 Port `busy_s`, output, 1 bit: conversion in progress.
REQ-008 Port `done_s`, output, 1 bit: one-cycle pulse when `sseg_s` has been updated.
REQ-009 Port `ovf_s`, output, 1 bit: last accepted value exceeded 9999.

Function
REQ-010 Segment byte format SHALL be {dp,g,f,e,d,c,b,a}, active-low (0 = lit), common-anode.
REQ-011 Digit codes SHALL be 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 (hex); a set `dp_s` bit SHALL clear bit 7 of that digit's byte.
REQ-012 FSM states SHALL be IDLE, SHIFT, ENCODE.
REQ-013 In IDLE, `load_s`=1 at edge k SHALL latch `val_s` and `dp_s`, set `busy_s`, clear the BCD accumulator and the 4-bit shift counter, and enter SHIFT.
REQ-014 SHIFT SHALL run iterative double-dabble: each cycle add 3 to any BCD nibble >=5, then shift one bit in MSB-first; exactly 14 cycles (edges k+1..k+14).
REQ-015 At edge k+15 (ENCODE), `sseg_s` SHALL be written from the final BCD digits, `done_s` SHALL be 1 for exactly one cycle, `busy_s` SHALL clear, and the FSM SHALL return to IDLE; latency load-to-done = 15 cycles.
REQ-016 `sseg_s` SHALL change only at ENCODE, all 32 bits together, so the scanner never sees a partial result.
REQ-017 If the latched value is >9999, ENCODE SHALL write BFBFBFBF (four dashes, `dp_s` ignored) and set `ovf_s`; otherwise it SHALL clear `ovf_s`; same 15-cycle latency.
REQ-018 `load_s` while `busy_s`=1 SHALL be ignored; the latched operands SHALL not change.
REQ-019 `load_s` held high SHALL start a new conversion on the first IDLE cycle after `done_s`, giving back-to-back conversions every 16 cycles.
REQ-020 `val_s` and `dp_s` changes outside the load edge SHALL have no effect.

Reset
REQ-021 `rst_s`=0 SHALL immediately force the following, at any time including mid-conversion: FSM=IDLE, `sseg_s`=FFFFFFFF (all segments off), `busy_s`=0, `done_s`=0, `ovf_s`=0, accumulator and counter=0.
REQ-022 The first `load_s` SHALL be accepted on the first rising edge after `rst_s` deasserts.

Configuration
REQ-023 Macro SSEG_LZ_BLANK_EN: when defined, leading zero digits (thousands, hundreds, tens, scanning from the left until the first nonzero digit) SHALL encode as FF, or 7F if their `dp_s` bit is set; units is never blanked.
REQ-024 Without SSEG_LZ_BLANK_EN, all four digits SHALL always be shown, including leading zeros.

Verification
REQ-025 Reset, then `val_s`=1234, `dp_s`=0, one-cycle `load_s` -> `busy_s` high 15 cycles, then `done_s` pulse, `sseg_s`=F9A4B099, `ovf_s`=0.
REQ-026 `val_s`=7 -> `sseg_s`=C0C0C0F8 without the macro; FFFFFFF8 with SSEG_LZ_BLANK_EN. `val_s`=0 with the macro -> FFFFFFC0.
REQ-027 `val_s`=10000 -> `sseg_s`=BFBFBFBF, `ovf_s`=1; a following load of 9999 -> 90909090, `ovf_s`=0.
REQ-028 `val_s`=5, `dp_s`=0100 -> C040C092 without the macro; FF7FFF92 with it.
REQ-029 Load 1234, pulse `load_s` with 4321 at cycle 5, then assert `rst_s`=0 at cycle 10 of a second conversion -> first result F9A4B099 (second request ignored); after reset, `sseg_s`=FFFFFFFF, `busy_s`=0 asynchronously, with no `done_s` pulse.
